// File: rtl/tsb_pkg.sv
// tsb_pkg: shared types and helpers for tristate_bus_arbiter.
//   state_t       : arbiter FSM states {IDLE, OWN, TURN}
//   TCNT_W        : width of the turnaround counter
//   MAX_N         : largest supported requester count
//   to_onehot()   : index -> one-hot vector (MAX_N bits)
//   lowest_index(): index of the lowest set bit of a MAX_N-bit vector
package tsb_pkg;

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

  localparam int unsigned TCNT_W = 4;
  localparam int unsigned MAX_N  = 16;

  function automatic logic [MAX_N-1:0] to_onehot(input logic [3:0] idx);
    logic [MAX_N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [3:0] lowest_index(input logic [MAX_N-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int unsigned i = MAX_N; i > 0; i--) begin
      if (v[i-1]) idx = 4'(i - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req    in  N   request vector
//   ptr    in  PW  highest-priority index for this round
//   winner out PW  first set req bit at or after ptr, searching upward cyclically
//   valid  out 1   any request present
module rr_pick
  import tsb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] winner,
  output logic          valid
);

  logic [MAX_N-1:0] all_req;
  logic [MAX_N-1:0] upper_req;

  // Cyclic search split in two: requests at or above ptr win first,
  // otherwise the lowest request overall (the wrap-around part) wins.
  // This stays correct for non-power-of-two N.
  always_comb begin
    all_req   = '0;
    upper_req = '0;
    for (int unsigned i = 0; i < N; i++) begin
      all_req[i]   = req[i];
      upper_req[i] = req[i] && (i >= 32'(ptr));
    end
    valid  = |req;
    winner = (|upper_req) ? PW'(lowest_index(upper_req))
                          : PW'(lowest_index(all_req));
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter: N-channel round-robin arbiter driving a shared
// WIDTH-bit tri-state bus with bounded ownership and enforced turnaround.
//   clk     in   clock (rising edge)
//   rst     in   synchronous active-high reset
//   req     in   N request bits
//   din     in   N*WIDTH data, requester i at [i*WIDTH +: WIDTH]
//   gnt     out  registered one-hot grant
//   owner   out  granted index, 0 when no grant
//   bus_oe  out  high while the bus is actively driven (OWN)
//   bus     out  owner's data when bus_oe, else z
//   nor_out out  ~|bus when bus_oe, else z
//   busy    out  high in OWN or TURN
// Optional macro BUS_KEEPER_EN: when bus_oe=0 the bus holds the last owned
// value (reset 0) and nor_out drives ~|keeper instead of z.
module tristate_bus_arbiter
  import tsb_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned MAX_HOLD    = 4,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   din,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] owner,
  output logic                 bus_oe,
  output logic [WIDTH-1:0]     bus,
  output logic                 nor_out,
  output logic                 busy
);

  localparam int unsigned PW = $clog2(N);
  localparam int unsigned CW = $clog2(MAX_HOLD + 1);

  if (N < 2 || N > MAX_N) begin : g_bad_n
    $error("tristate_bus_arbiter: N must be 2..16");
  end
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("tristate_bus_arbiter: WIDTH must be 1..64");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("tristate_bus_arbiter: MAX_HOLD must be 1..255");
  end
  if (TURN_CYCLES < 1 || TURN_CYCLES > 15) begin : g_bad_turn
    $error("tristate_bus_arbiter: TURN_CYCLES must be 1..15");
  end

  state_t              state, state_n;
  logic [N-1:0]        gnt_n;
  logic [PW-1:0]       owner_n, ptr, ptr_n, win;
  logic                win_valid, release_own;
  logic [CW-1:0]       cnt, cnt_n;
  logic [TCNT_W-1:0]   tcnt, tcnt_n;
  logic [WIDTH-1:0]    drive;

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (win),
    .valid  (win_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
      tcnt  <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      owner <= owner_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      tcnt  <= tcnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    gnt_n       = gnt;
    owner_n     = owner;
    ptr_n       = ptr;
    cnt_n       = cnt;
    tcnt_n      = tcnt;
    release_own = 1'b0;
    case (state)
      IDLE: begin
        if (win_valid) begin
          gnt_n   = N'(to_onehot(4'(win)));
          owner_n = win;
          cnt_n   = CW'(1);
          state_n = OWN;
        end
      end
      OWN: begin
        release_own = !req[owner] || (cnt == CW'(MAX_HOLD));
        if (release_own) begin
          gnt_n   = '0;
          owner_n = '0;
          ptr_n   = (owner == PW'(N - 1)) ? '0 : owner + 1'b1;
          tcnt_n  = TCNT_W'(1);
          state_n = TURN;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      TURN: begin
        if (tcnt >= TCNT_W'(TURN_CYCLES)) state_n = IDLE;
        else                              tcnt_n  = tcnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus_oe = (state == OWN);
  assign busy   = (state != IDLE);
  assign drive  = din[owner*WIDTH +: WIDTH];

`ifdef BUS_KEEPER_EN
  logic [WIDTH-1:0] keeper;

  always_ff @(posedge clk) begin
    if (rst)         keeper <= '0;
    else if (bus_oe) keeper <= drive;
  end

  assign bus     = bus_oe ? drive : keeper;
  assign nor_out = bus_oe ? ~|drive : ~|keeper;
`else
  assign bus     = bus_oe ? drive : 'z;
  assign nor_out = bus_oe ? ~|drive : 1'bz;
`endif

endmodule

// File: doc/tristate_bus_arbiter.md
# tristate_bus_arbiter

Parametrised N-channel, WIDTH-bit tri-state bus driver with round-robin arbitration, bounded ownership and enforced turnaround. Several requesters share one tri-state bus. The block grants exactly one requester at a time and drives that requester's data onto the bus. It also drives a tri-state NOR of the bus value, generalising the single-bit high-Z NOR gate to multi-bit, multi-source buses. The block sits between datapath sources and any shared internal bus.

## Interface
Parameters:
- N, 4, number of requesters (2..16)
- WIDTH, 8, bus data width (1..64)
- MAX_HOLD, 4, maximum consecutive grant cycles per ownership (1..255)
- TURN_CYCLES, 1, mandatory idle bus cycles after each ownership (1..15)

Ports:
- clk  in  1  rising-edge clock; one clock domain
- rst  in  1  synchronous, active-high reset
- req  in  N  request vector; bit i belongs to requester i
- din  in  N*WIDTH  requester data; requester i occupies bits [i*WIDTH +: WIDTH]
- gnt  out  N  one-hot grant, registered
- owner  out  $clog2(N)  index of the granted requester; 0 when no grant
- bus_oe  out  1  high while the bus is driven
- bus  out  WIDTH  tri-state bus; equals din of owner when bus_oe=1, else all-z
- nor_out  out  1  ~|bus when bus_oe=1, else z
- busy  out  1  high in OWN or TURN

## Operation
- The state machine has three states: IDLE, OWN and TURN.
- IDLE:
  - gnt=0, bus_oe=0.
  - If |req, the winner W is the first set req bit at or after ptr, searching upward cyclically.
  - On that edge: gnt<=onehot(W), owner<=W, cnt<=1, next state OWN.
- OWN:
  - bus_oe=1; bus = din[W] combinationally, so din changes appear on bus in the same cycle.
  - Requests from non-owners are ignored.
  - Release occurs at an edge where req[W]==0 or cnt==MAX_HOLD.
  - On release: gnt<=0, owner<=0, ptr<=(W+1) mod N, tcnt<=1, next state TURN.
  - Otherwise cnt<=cnt+1.
- TURN:
  - gnt=0, bus_oe=0.
  - Stays in TURN while tcnt<TURN_CYCLES, with tcnt incrementing each cycle.
  - At tcnt==TURN_CYCLES the next state is IDLE; IDLE arbitrates on its first cycle.
- Width rules:
  - ptr is $clog2(N) bits with explicit wrap from N-1 to 0; it must also be correct for non-power-of-two N.
  - cnt is $clog2(MAX_HOLD+1) bits and tcnt is 4 bits; neither counter may overflow.
- Reset (any cycle, including mid-OWN):
  - Next cycle: state IDLE, gnt=0, owner=0, ptr=0, cnt=0, tcnt=0, bus_oe=0, bus=z, nor_out=z, busy=0.
- Boundary behaviour:
  - All req bits low in IDLE: the block stays in IDLE.
  - Owner re-requests during TURN: it is rearbitrated in IDLE at lower priority than the requesters after it.
  - N=1 is rejected by elaboration check; N=2 must alternate correctly.

## Timing
- Request-to-grant latency: req sampled high in IDLE at edge k gives gnt high in cycle k+1.
- Grant duration: at most MAX_HOLD cycles. When req[W] is sampled low at edge k, gnt is still high in cycle k and low from k+1.
- Minimum gap between two ownerships: TURN_CYCLES+1 cycles of bus_oe=0 (TURN cycles plus one IDLE arbitration cycle).
- bus, bus_oe and nor_out are combinational from registered state and din; they carry no extra register stage.

## Configuration
- BUS_KEEPER_EN undefined: when bus_oe=0, bus and nor_out are z.
- BUS_KEEPER_EN defined:
  - A WIDTH-bit keeper register captures bus on every OWN cycle and resets to 0.
  - When bus_oe=0, bus drives the keeper value and nor_out drives ~|keeper.
  - bus_oe keeps its meaning (active driver present).

## Structure
- Package tsb_pkg holds:
  - the state enum {IDLE, OWN, TURN};
  - the TURN counter width constant (4);
  - the onehot and index helper functions.
- One sub-module, rr_pick:
  - combinational round-robin picker;
  - inputs req[N] and ptr; outputs winner index and a valid flag;
  - instantiated once.

## Test plan
- Reset/idle: rst=1 for 2 cycles, then req=0 → gnt=0, owner=0, bus=z (or 0 with BUS_KEEPER_EN), nor_out=z, busy=0.
- Single grant: req=4'b0100, din[2]=8'h00 → gnt=4'b0100 one cycle later, bus=8'h00, nor_out=1; din[2]=8'hA5 → nor_out=0.
- Round-robin: req=4'b1111 held, MAX_HOLD=4, TURN_CYCLES=1 → owners 0,1,2,3,0, each exactly 4 gnt cycles, separated by exactly 2 cycles with bus_oe=0.
- Early release: owner 1 drops req after 2 grant cycles → gnt low on the next cycle, ptr=2; req=4'b0011 then grants 0 (wrap), not 1.
- Reset mid-OWN: rst asserted in the 3rd OWN cycle of owner 3 → gnt=0, bus=z, ptr=0 the next cycle; req=4'b1000 re-grants 3 after rst releases.
- Non-owner noise: while owner 0 holds the grant, toggle req[3:1] every cycle → gnt stays 4'b0001 until release; only one gnt bit is ever set and bus_oe=|gnt always holds.
